// File: rtl/uart_rx_fsm_if.sv
// Receiver-side bundle: serial line and host acknowledge in, received word and status flags out.
// The receiver uses the slave modport; the host/driver side uses master.
interface uart_rx_fsm_if #(
  parameter int WORD_LENGTH = 8
);
  logic                   rx;
  logic                   clear_rx_flag;
  logic [WORD_LENGTH-1:0] rx_data;
  logic                   rx_flag;
  logic                   frame_error;
  logic                   overrun_error;

  modport master (
    output rx, clear_rx_flag,
    input  rx_data, rx_flag, frame_error, overrun_error
  );

  modport slave (
    input  rx, clear_rx_flag,
    output rx_data, rx_flag, frame_error, overrun_error
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// Oversampling UART receiver: synchronised line, mid-bit sampling, sticky word/overrun flags
// and a per-frame stop-bit check. Host handshake: rx_flag rises when a word lands in rx_data
// and stays high until clear_rx_flag is seen on a clock edge; a set in the same edge wins.
module uart_rx_fsm #(
  parameter int WORD_LENGTH = 8,
  parameter int SAMPLE_DIV  = 13,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                clk,
  input  logic                reset,
  uart_rx_fsm_if.slave        bus,
  output logic [2:0]          dbg_state
);

  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SMP_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [SMP_W-1:0]  HALF_LAST = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0]  FULL_LAST = SMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_meta_d;
  logic                   rx_s_q, rx_s_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic [SMP_W-1:0]       sample_cnt_q, sample_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic                   stop_ok_q, stop_ok_d;
  logic [WORD_LENGTH-1:0] rx_data_q, rx_data_d;
  logic                   rx_flag_q, rx_flag_d;
  logic                   frame_error_q, frame_error_d;
  logic                   overrun_q, overrun_d;
  logic                   tick;
  logic [WORD_LENGTH:0]   shift_ext;

  always_comb begin
    state_d       = state_q;
    rx_meta_d     = bus.rx;
    rx_s_d        = rx_meta_q;
    rx_prev_d     = rx_s_q;
    sample_cnt_d  = sample_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    stop_ok_d     = stop_ok_q;
    rx_data_d     = rx_data_q;
    rx_flag_d     = rx_flag_q;
    frame_error_d = frame_error_q;
    overrun_d     = overrun_q;
    shift_ext     = {rx_s_q, shift_q};

    tick = (state_q != IDLE) && (tick_cnt_q == TICK_LAST);
    if (state_q == IDLE || tick) tick_cnt_d = '0;
    else                         tick_cnt_d = tick_cnt_q + TICK_W'(1);

    // Host acknowledge; the DONE branch below overrides it when a word lands this clock.
    if (bus.clear_rx_flag) begin
      rx_flag_d = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d      = START;
          sample_cnt_d = '0;
          bit_cnt_d    = '0;
        end
      end
      START: begin
        if (tick) begin
          if (sample_cnt_q == HALF_LAST) begin
            sample_cnt_d = '0;
            state_d      = rx_s_q ? IDLE : DATA;
          end else begin
            sample_cnt_d = sample_cnt_q + SMP_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (sample_cnt_q == FULL_LAST) begin
            sample_cnt_d = '0;
            shift_d      = shift_ext[WORD_LENGTH:1];
            bit_cnt_d    = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_LAST) state_d = STOP;
          end else begin
            sample_cnt_d = sample_cnt_q + SMP_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (sample_cnt_q == FULL_LAST) begin
            sample_cnt_d  = '0;
            frame_error_d = ~rx_s_q;
            stop_ok_d     = rx_s_q;
            state_d       = DONE;
          end else begin
            sample_cnt_d = sample_cnt_q + SMP_W'(1);
          end
        end
      end
      DONE: begin
        // A bad stop bit still publishes the word but never counts as a new arrival.
        rx_data_d = shift_q;
        if (stop_ok_q) begin
          rx_flag_d = 1'b1;
          if (rx_flag_q) overrun_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      tick_cnt_q    <= '0;
      sample_cnt_q  <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      stop_ok_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_flag_q     <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_meta_q     <= rx_meta_d;
      rx_s_q        <= rx_s_d;
      rx_prev_q     <= rx_prev_d;
      tick_cnt_q    <= tick_cnt_d;
      sample_cnt_q  <= sample_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      stop_ok_q     <= stop_ok_d;
      rx_data_q     <= rx_data_d;
      rx_flag_q     <= rx_flag_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_flag       = rx_flag_q;
  assign bus.frame_error   = frame_error_q;
  assign bus.overrun_error = overrun_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: frames are driven bit by bit, the expected word/flags are
// queued by the driver and checked by a monitor one clock after the receiver leaves DONE.
module tb_uart_rx_fsm;
  localparam int W        = 8;
  localparam int EW       = W + 3;
  localparam int BIT_CLKS = 208;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] dbg_state;

  uart_rx_fsm_if #(.WORD_LENGTH(W)) bus ();

  uart_rx_fsm #(.WORD_LENGTH(W), .SAMPLE_DIV(13), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state: {overrun, frame_error, rx_flag, rx_data}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_w;
  logic [W-1:0]  m_data = '0;
  bit            m_flag = 0, m_ferr = 0, m_ovr = 0;
  int            n_cmp = 0, n_bad = 0;
  int            start_cyc = 0;
  int            lat;
  bit            done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_rx_data"}, 32'(bus.rx_data), 32'(m_data));
    chk({tag, "_rx_flag"}, 32'(bus.rx_flag), 32'(m_flag));
    chk({tag, "_frame_error"}, 32'(bus.frame_error), 32'(m_ferr));
    chk({tag, "_overrun"}, 32'(bus.overrun_error), 32'(m_ovr));
  endtask

  // monitor: the word and flags are registered on the edge that leaves DONE
  always @(negedge clk) begin
    if (done_seen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'(bus.rx_data), 32'hFFFF_FFFF);
      end else begin
        mon_w = exp_q.pop_front();
        lat = cyc - start_cyc;
        chk("mon_rx_data", 32'(bus.rx_data), 32'(mon_w[W-1:0]));
        chk("mon_rx_flag", 32'(bus.rx_flag), 32'(mon_w[W]));
        chk("mon_frame_error", 32'(bus.frame_error), 32'(mon_w[W+1]));
        chk("mon_overrun", 32'(bus.overrun_error), 32'(mon_w[W+2]));
        chk("mon_latency_1976_1980", 32'(lat >= 1976 && lat <= 1980), 32'd1);
      end
    end
    done_seen = reset && (dbg_state == ST_DONE);
  end

  // driver tasks: every line change happens on a falling clock edge
  task automatic hold_line(input logic v, input int n, input bit clr_in_done);
    bus.rx = v;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.clear_rx_flag = clr_in_done && (dbg_state == ST_DONE);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input bit stop, input bit clr_in_done);
    m_data = d;
    m_ferr = !stop;
    if (stop) begin
      if (m_flag)           m_ovr = 1;
      else if (clr_in_done) m_ovr = 0;
      m_flag = 1;
    end else if (clr_in_done) begin
      m_flag = 0;
      m_ovr  = 0;
    end
    exp_q.push_back({m_ovr, m_ferr, m_flag, m_data});
    @(negedge clk);
    start_cyc = cyc;
    hold_line(1'b0, BIT_CLKS, 0);
    for (int i = 0; i < W; i++) hold_line(d[i], BIT_CLKS, 0);
    hold_line(stop, BIT_CLKS, clr_in_done);
    hold_line(1'b1, 300, 0);
  endtask

  task automatic host_clear();
    @(negedge clk);
    bus.clear_rx_flag = 1'b1;
    @(negedge clk);
    bus.clear_rx_flag = 1'b0;
    m_flag = 0;
    m_ovr  = 0;
    chk_outputs("after_clear");
  endtask

  task automatic glitch(input int n);
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (n) @(negedge clk);
    bus.rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk_outputs("after_glitch");
  endtask

  task automatic reset_mid_frame(input logic [W-1:0] d);
    @(negedge clk);
    hold_line(1'b0, BIT_CLKS, 0);
    for (int i = 0; i < 4; i++) hold_line(d[i], BIT_CLKS, 0);
    hold_line(d[4], 100, 0);
    reset  = 1'b0;
    bus.rx = 1'b1;
    m_data = '0;
    m_flag = 0;
    m_ferr = 0;
    m_ovr  = 0;
    repeat (3) @(negedge clk);
    chk("midreset_state", 32'(dbg_state), 32'(ST_IDLE));
    chk_outputs("in_midreset");
    reset = 1'b1;
    repeat (300) @(negedge clk);
    chk("post_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    chk_outputs("post_reset");
  endtask

  initial begin
    bus.rx            = 1'b1;
    bus.clear_rx_flag = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    chk_outputs("reset");
    reset = 1'b1;
    repeat (20) @(negedge clk);

    send_frame(8'hA5, 1'b1, 0);
    glitch(50);
    send_frame(8'h3C, 1'b0, 0);
    host_clear();
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    host_clear();
    send_frame(8'h96, 1'b1, 1);
    reset_mid_frame(8'h5A);
    send_frame(8'h5A, 1'b1, 0);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 8, data bits per frame.
REQ-002 The block SHALL have parameter SAMPLE_DIV, default 13, clk cycles per oversample tick.
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, ticks per bit; it SHALL be even.
REQ-004 The block SHALL have port clk  input  1  system clock, all state updated on rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 The block SHALL have port clear_rx_flag  input  1  host acknowledge; clears rx_flag and overrun_error.
REQ-008 The block SHALL have port rx_data  output  WORD_LENGTH  last received word, registered.
REQ-009 The block SHALL have port rx_flag  output  1  word available, sticky until cleared.
REQ-010 The block SHALL have port frame_error  output  1  last frame had a low stop bit.
REQ-011 The block SHALL have port overrun_error  output  1  word received while rx_flag was already 1.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer (rx_s), both flops reset to 1; all decisions use rx_s only.
REQ-013 The tick counter SHALL count 0..SAMPLE_DIV-1 outside IDLE, issue a one-clk tick at SAMPLE_DIV-1, then wrap to 0; it SHALL be held at 0 in IDLE.
REQ-014 States SHALL be IDLE, START, DATA, STOP and DONE; the reset state SHALL be IDLE.
REQ-015 In IDLE, a falling edge of rx_s (previous 1, current 0) SHALL move the FSM to START and clear the tick and bit counters.
REQ-016 In START, on tick OVERSAMPLE/2, rx_s==0 SHALL move the FSM to DATA; rx_s==1 SHALL be treated as a glitch and return the FSM to IDLE with no output change.
REQ-017 In DATA, every OVERSAMPLE ticks rx_s SHALL be shifted into the MSB of a WORD_LENGTH shift register (LSB first on the line).
REQ-018 In DATA, after WORD_LENGTH samples the FSM SHALL move to STOP.
REQ-019 In STOP, rx_s SHALL be sampled after OVERSAMPLE ticks; frame_error SHALL be loaded with the inverse of the sample; the FSM SHALL then go to DONE.
REQ-020 DONE SHALL last exactly one clk and SHALL load rx_data from the shift register, set rx_flag=1 if the stop sample was 1, and set overrun_error=1 if rx_flag was already 1.
REQ-021 On a framing error, rx_data SHALL still be updated and rx_flag SHALL keep its previous value.
REQ-022 DONE SHALL always return the FSM to IDLE; a new start SHALL be accepted only on a fresh falling edge of rx_s.
REQ-023 clear_rx_flag SHALL clear rx_flag and overrun_error on the next clk; if set and clear occur in the same clk, set SHALL win.
REQ-024 clear_rx_flag SHALL NOT affect frame_error, which updates only at each stop sample.
REQ-025 Bit period SHALL be SAMPLE_DIV*OVERSAMPLE clk (208 at defaults); sampling SHALL occur at mid-bit.
REQ-026 Unreachable state encodings SHALL return the FSM to IDLE on the next clk.

Reset
REQ-027 While reset==0, the FSM SHALL be in IDLE, all counters and the shift register SHALL be 0, rx_data SHALL be 0, and rx_flag, frame_error and overrun_error SHALL be 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no output update; after release the FSM SHALL wait for a new falling edge.

Verification
REQ-029 Send 0xA5 at 208 clk/bit with a valid stop bit -> rx_data=0xA5, rx_flag=1, frame_error=0, rising 1976-1980 clk after the start edge.
REQ-030 Low pulse of 50 clk on idle rx -> START aborts at mid-bit, FSM returns to IDLE, all outputs unchanged.
REQ-031 Send 0x3C with the stop bit held low -> rx_data=0x3C, frame_error=1, rx_flag unchanged; a following valid frame clears frame_error.
REQ-032 Send two frames (0x11, then 0x22) without asserting clear_rx_flag -> rx_data=0x22, rx_flag=1, overrun_error=1; then clear_rx_flag for 1 clk -> both flags 0.
REQ-033 Assert clear_rx_flag in the DONE clk of a frame -> rx_flag=1 after that edge (set wins).
REQ-034 Pulse reset low during data bit 4 of a frame -> all outputs 0; the next complete frame 0x5A is received correctly.
